sram_responder: RTL

- Synthesizable responder for the external SRAM interface: address, bidirectional 8-bit data, active-low write strobe.
- Emulates an SRAM chip backed by on-chip block RAM so SRAM test and production cores can run in simulation or on boards without the external part.
- Smaller chips are modelled by address aliasing: upper address bits are ignored.
- Flags initiator protocol violations: address changing during a write pulse, over-long write pulses.

---
 rtl/sram_responder.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/sram_responder.sv
// SRAM chip emulator on block RAM: byte-wide async-style SRAM pins sampled on clk,
// address aliasing by truncation, and sticky flags for initiator protocol violations.
module sram_responder #(
  parameter int ADDR_BITS     = 19,
  parameter int MAX_WE_CYCLES = 4,
  parameter int TURNAROUND    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [20:0] sram_a,
  inout  logic [7:0]  sram_d,
  input  logic        sram_we_n,
  output logic [21:0] wr_count,
  output logic        addr_err,
  output logic        pulse_err,
  output logic        busy
);

  localparam int PW    = $clog2(MAX_WE_CYCLES + 1);
  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [PW-1:0] PMAX  = PW'(MAX_WE_CYCLES);
  localparam logic [1:0]    TINIT = 2'(TURNAROUND - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WLOW   = 2'd1,
    COMMIT = 2'd2,
    TURN   = 2'd3
  } state_t;

  state_t                 state_r, state_nxt_s;
  logic [7:0]             mem_r [DEPTH];
  logic [ADDR_BITS-1:0]   am_s, wa_r;
  logic [7:0]             wd_r, rd_data_r;
  logic [PW-1:0]          pcnt_r;
  logic [1:0]             tcnt_r;
  logic [21:0]            wr_count_r;
  logic                   addr_err_r, pulse_err_r, busy_r;
  logic                   drive_s, commit_s;

  assign am_s     = sram_a[ADDR_BITS-1:0];
  assign commit_s = (state_r == COMMIT);

  // The bus is released combinationally the moment the strobe falls.
  assign drive_s = rst_n & sram_we_n & (state_r == IDLE);
  assign sram_d  = drive_s ? rd_data_r : 8'hzz;

  assign wr_count  = wr_count_r;
  assign addr_err  = addr_err_r;
  assign pulse_err = pulse_err_r;
  assign busy      = busy_r;

  generate
    if (ADDR_BITS < 21) begin : g_alias
      logic unused_s;
      assign unused_s = ^sram_a[20:ADDR_BITS];
    end
  endgenerate

  // Next-state decode for the write handshake.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (!sram_we_n) state_nxt_s = WLOW;
        else            state_nxt_s = IDLE;
      end
      WLOW: begin
        if (sram_we_n) state_nxt_s = COMMIT;
        else           state_nxt_s = WLOW;
      end
      COMMIT: begin
        if (TINIT == 2'd0) state_nxt_s = IDLE;
        else               state_nxt_s = TURN;
      end
      TURN: begin
        if (tcnt_r <= 2'd1) state_nxt_s = IDLE;
        else                state_nxt_s = TURN;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Write capture, pulse/turnaround counters, statistics and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      wa_r        <= '0;
      wd_r        <= 8'h00;
      pcnt_r      <= '0;
      tcnt_r      <= 2'd0;
      wr_count_r  <= 22'd0;
      addr_err_r  <= 1'b0;
      pulse_err_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
      case (state_r)
        IDLE: begin
          if (!sram_we_n) begin
            wa_r   <= am_s;
            wd_r   <= sram_d;
            pcnt_r <= PW'(1);
          end
        end
        WLOW: begin
          if (!sram_we_n) begin
            wd_r <= sram_d;
            if (pcnt_r != PMAX) pcnt_r <= pcnt_r + PW'(1);
            else                pulse_err_r <= 1'b1;
            if (am_s != wa_r) addr_err_r <= 1'b1;
          end
        end
        COMMIT: begin
          if (wr_count_r != 22'h3FFFFF) wr_count_r <= wr_count_r + 22'd1;
          tcnt_r <= TINIT;
          // A strobe already low here left no gap after the previous pulse.
          if (!sram_we_n) pulse_err_r <= 1'b1;
        end
        TURN: begin
          if (tcnt_r != 2'd0) tcnt_r <= tcnt_r - 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (commit_s && rst_n) mem_r[wa_r] <= wd_r;
  end

  // Registered read with write-first bypass during commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r <= 8'h00;
    end else if (commit_s && (am_s == wa_r)) begin
      rd_data_r <= wd_r;
    end else begin
      rd_data_r <= mem_r[am_s];
    end
  end

endmodule
